// File: rtl/cim_cmd_sequencer.sv
// ============================================================================
// Module   : cim_cmd_sequencer
// Purpose  : Host-command sequencer for the CIM array. Holds each array
//            operation for HOLD_CYC cycles and auto-increments write bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cim_cmd_sequencer #(
    parameter int HOLD_CYC = 2,
    parameter int LEN_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [8:0]       cmd_addr,
    input  logic [15:0]      cmd_bank,
    input  logic [15:0]      cmd_din,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [15:0]      wd_data,
    output logic [1:0]       op_code,
    output logic [8:0]       addr,
    output logic [15:0]      data_bank,
    output logic [15:0]      data_in,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_WD  = 2'd1;
    localparam logic [1:0] c_DRIVE    = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_NOP   = 2'b11;

    localparam logic [3:0]       c_HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic             c_SINGLE_HOLD = (HOLD_CYC == 1);
    localparam logic [LEN_W-1:0] c_CNT_ONE     = LEN_W'(1);

    logic [1:0]       r_state, w_state;
    logic [3:0]       r_hold, w_hold;
    logic [LEN_W-1:0] r_cnt, w_cnt;
    logic             r_is_wr, w_is_wr;
    logic [1:0]       r_op, w_op;
    logic [8:0]       r_addr, w_addr;
    logic [15:0]      r_bank, w_bank;
    logic [15:0]      r_din, w_din;
    logic             r_cmd_ready, w_cmd_ready;
    logic             r_wd_ready, w_wd_ready;
    logic             r_done, w_done;

    logic [8:0]       w_addr_inc;
    logic             w_more;

    // Only the bank/row field advances; the column stays at the command's value.
    assign w_addr_inc = {r_addr[8:3] + 6'd1, r_addr[2:0]};
    assign w_more     = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_op        <= c_OP_NOP;
            r_addr      <= '0;
            r_bank      <= '0;
            r_din       <= '0;
            r_cmd_ready <= 1'b0;
            r_wd_ready  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_hold      <= w_hold;
            r_cnt       <= w_cnt;
            r_is_wr     <= w_is_wr;
            r_op        <= w_op;
            r_addr      <= w_addr;
            r_bank      <= w_bank;
            r_din       <= w_din;
            r_cmd_ready <= w_cmd_ready;
            r_wd_ready  <= w_wd_ready;
            r_done      <= w_done;
        end
    end

    // Outputs are registered, so every w_* value describes the next cycle.
    always_comb begin
        w_state     = r_state;
        w_hold      = r_hold;
        w_cnt       = r_cnt;
        w_is_wr     = r_is_wr;
        w_op        = c_OP_NOP;
        w_addr      = r_addr;
        w_bank      = r_bank;
        w_din       = r_din;
        w_cmd_ready = 1'b0;
        w_wd_ready  = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_hold = '0;
                    case (cmd_op)
                        c_OP_NOP: begin
                            w_state = c_DONE;
                            w_done  = 1'b1;
                        end
                        c_OP_WRITE: begin
                            w_state    = c_WAIT_WD;
                            w_addr     = cmd_addr;
                            w_cnt      = cmd_len;
                            w_is_wr    = 1'b1;
                            w_wd_ready = 1'b1;
                        end
                        default: begin
                            w_state = c_DRIVE;
                            w_is_wr = 1'b0;
                            w_op    = cmd_op;
                            w_addr  = cmd_addr;
                            w_bank  = cmd_bank;
                            w_din   = cmd_din;
                        end
                    endcase
                end else begin
                    w_cmd_ready = 1'b1;
                end
            end

            c_WAIT_WD: begin
                if (wd_valid && r_wd_ready) begin
                    w_state    = c_DRIVE;
                    w_op       = c_OP_WRITE;
                    w_bank     = wd_data;
                    w_din      = '0;
                    w_hold     = '0;
                    w_wd_ready = c_SINGLE_HOLD && w_more;
                end else begin
                    w_wd_ready = 1'b1;
                end
            end

            c_DRIVE: begin
                if (r_hold != c_HOLD_LAST) begin
                    w_op       = r_op;
                    w_hold     = r_hold + 4'd1;
                    w_wd_ready = r_is_wr && w_more && ((r_hold + 4'd1) == c_HOLD_LAST);
                end else if (r_is_wr && w_more) begin
                    w_addr = w_addr_inc;
                    w_cnt  = r_cnt - c_CNT_ONE;
                    if (wd_valid && r_wd_ready) begin
                        w_op       = c_OP_WRITE;
                        w_bank     = wd_data;
                        w_din      = '0;
                        w_hold     = '0;
                        w_wd_ready = c_SINGLE_HOLD && (r_cnt != c_CNT_ONE);
                    end else begin
                        w_state    = c_WAIT_WD;
                        w_wd_ready = 1'b1;
                    end
                end else begin
                    w_state = c_DONE;
                    w_done  = 1'b1;
                end
            end

            default: begin
                w_state     = c_IDLE;
                w_cmd_ready = 1'b1;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign wd_ready  = r_wd_ready;
    assign op_code   = r_op;
    assign addr      = r_addr;
    assign data_bank = r_bank;
    assign data_in   = r_din;
    assign done      = r_done;
    assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cim_cmd_sequencer.sv
// ============================================================================
// Module   : tb_cim_cmd_sequencer
// Purpose  : Cycle-by-cycle vector table plus handshake/latency sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cim_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [15:0] cmd_bank;
    logic [15:0] cmd_din;
    logic [5:0]  cmd_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [15:0] wd_data;
    logic [1:0]  op_code;
    logic [8:0]  addr;
    logic [15:0] data_bank;
    logic [15:0] data_in;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    cim_cmd_sequencer #(.HOLD_CYC(2), .LEN_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_bank(cmd_bank), .cmd_din(cmd_din), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .op_code(op_code), .addr(addr), .data_bank(data_bank), .data_in(data_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        cv;
        logic [1:0]  op;
        logic [8:0]  a;
        logic [15:0] bank;
        logic [15:0] din;
        logic [5:0]  len;
        logic        wv;
        logic [15:0] wd;
        logic [1:0]  e_op;
        logic [8:0]  e_addr;
        logic [15:0] e_bank;
        logic [15:0] e_din;
        logic        e_crdy;
        logic        e_wrdy;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic cv, input logic [1:0] op, input logic [8:0] a,
                       input logic [15:0] bank, input logic [15:0] din, input logic [5:0] len,
                       input logic wv, input logic [15:0] wd,
                       input logic [1:0] e_op, input logic [8:0] e_addr, input logic [15:0] e_bank,
                       input logic [15:0] e_din, input logic e_crdy, input logic e_wrdy,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.rst_n = r;  v.cv = cv; v.op = op; v.a = a; v.bank = bank; v.din = din; v.len = len;
        v.wv = wv; v.wd = wd; v.e_op = e_op; v.e_addr = e_addr; v.e_bank = e_bank; v.e_din = e_din;
        v.e_crdy = e_crdy; v.e_wrdy = e_wrdy; v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    int acc, mac_cyc, dn, lat;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_bank = '0;
        cmd_din = '0; cmd_len = '0; wd_valid = 1'b0; wd_data = '0;

        // Reset held with cmd_valid high, then release
        for (int i = 0; i < 3; i++)
            add(0,1,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,    2'd3,9'h000,16'h0000,16'h0000,0,0,0,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h000,16'h0000,16'h0000,1,0,0,0);
        // MAC
        add(1,1,2'd0,9'h000,16'h0010,16'hFFFF,6'd0,0,16'h0,  2'd0,9'h000,16'h0010,16'hFFFF,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd0,9'h000,16'h0010,16'hFFFF,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h000,16'h0010,16'hFFFF,0,0,1,1);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h000,16'h0010,16'hFFFF,1,0,0,0);
        // Gapless 4-beat write burst
        add(1,1,2'd1,9'h000,16'h0,16'h0,6'd3,0,16'h0,        2'd3,9'h000,16'h0010,16'hFFFF,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0000,     2'd1,9'h000,16'h0000,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0001,     2'd1,9'h000,16'h0000,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0001,     2'd1,9'h008,16'h0001,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0002,     2'd1,9'h008,16'h0001,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0002,     2'd1,9'h010,16'h0002,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0003,     2'd1,9'h010,16'h0002,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0003,     2'd1,9'h018,16'h0003,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h0003,     2'd1,9'h018,16'h0003,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'hDEAD,     2'd3,9'h018,16'h0003,16'h0000,0,0,1,1);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h018,16'h0003,16'h0000,1,0,0,0);
        // Stalled 2-beat write wrapping 0x1F8 -> 0x000
        add(1,1,2'd1,9'h1F8,16'h0,16'h0,6'd1,0,16'h0,        2'd3,9'h1F8,16'h0003,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'hAAAA,     2'd1,9'h1F8,16'hAAAA,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd1,9'h1F8,16'hAAAA,16'h0000,0,1,1,0);
        for (int i = 0; i < 3; i++)
            add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,    2'd3,9'h000,16'hAAAA,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h5555,     2'd1,9'h000,16'h5555,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd1,9'h000,16'h5555,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h000,16'h5555,16'h0000,0,0,1,1);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h000,16'h5555,16'h0000,1,0,0,0);
        // 8-beat burst from column 5, reset during beat 3
        add(1,1,2'd1,9'h005,16'h0,16'h0,6'd7,0,16'h0,        2'd3,9'h005,16'h5555,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h1000,     2'd1,9'h005,16'h1000,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h1001,     2'd1,9'h005,16'h1000,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h1001,     2'd1,9'h00D,16'h1001,16'h0000,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h1002,     2'd1,9'h00D,16'h1001,16'h0000,0,1,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h1002,     2'd1,9'h015,16'h1002,16'h0000,0,0,1,0);
        add(0,0,2'd0,9'h000,16'h0,16'h0,6'd0,1,16'h1003,     2'd3,9'h000,16'h0000,16'h0000,0,0,0,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h000,16'h0000,16'h0000,1,0,0,0);
        // CAM after the reset
        add(1,1,2'd2,9'h0A3,16'h000F,16'h1234,6'd0,0,16'h0,  2'd2,9'h0A3,16'h000F,16'h1234,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd2,9'h0A3,16'h000F,16'h1234,0,0,1,0);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h0A3,16'h000F,16'h1234,0,0,1,1);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h0A3,16'h000F,16'h1234,1,0,0,0);
        // NOP: straight to done, array stays parked
        add(1,1,2'd3,9'h1FF,16'hFFFF,16'hFFFF,6'd5,0,16'h0,  2'd3,9'h0A3,16'h000F,16'h1234,0,0,1,1);
        add(1,0,2'd0,9'h000,16'h0,16'h0,6'd0,0,16'h0,        2'd3,9'h0A3,16'h000F,16'h1234,1,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; cmd_valid = vecs[i].cv; cmd_op = vecs[i].op;
            cmd_addr = vecs[i].a; cmd_bank = vecs[i].bank; cmd_din = vecs[i].din;
            cmd_len = vecs[i].len; wd_valid = vecs[i].wv; wd_data = vecs[i].wd;
            @(posedge clk); #1;
            check($sformatf("vec%0d {op,addr,bank,din,crdy,wrdy,busy,done}", i),
                  64'({op_code, addr, data_bank, data_in, cmd_ready, wd_ready, busy, done}),
                  64'({vecs[i].e_op, vecs[i].e_addr, vecs[i].e_bank, vecs[i].e_din,
                       vecs[i].e_crdy, vecs[i].e_wrdy, vecs[i].e_busy, vecs[i].e_done}));
        end

        // cmd_valid held high across a whole MAC: exactly one accept
        rst_n = 1'b1; wd_valid = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 9'h1FF; cmd_bank = 16'h00FF; cmd_din = 16'h0F0F;
        acc = 0; mac_cyc = 0; dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) acc++;
            @(posedge clk); #1;
            if (op_code == 2'b00) begin
                mac_cyc++;
                check("mac_hold_data", 64'({addr, data_bank, data_in}), 64'({9'h1FF, 16'h00FF, 16'h0F0F}));
            end
            if (done) dn++;
        end
        check("held_valid_accepts", 64'(acc), 64'd1);
        check("mac_drive_cycles", 64'(mac_cyc), 64'd2);
        check("mac_done_pulses", 64'(dn), 64'd1);

        // Accept-to-done latency, bounded wait
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 9'h042; cmd_bank = 16'h1111; cmd_din = 16'h2222;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("cam_done_latency", 64'(lat), 64'd2);
        @(posedge clk); #1;
        check("idle_after_cam", 64'({op_code, cmd_ready, busy, done}), 64'({2'b11, 1'b1, 1'b0, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cim_cmd_sequencer.md
Name: cim_cmd_sequencer

Overview:
Command sequencer that sits directly upstream of the CIM array and drives its op_code/addr/data_bank/data_in interface. It accepts host commands over a valid/ready handshake. Weight writes can be bursts that auto-increment the bank/row address, with weight words taken from a separate valid/ready stream. Each array operation is held stable for HOLD_CYC cycles, and the array interface is parked at IDLE (op_code 2'b11) whenever no operation is being driven.

Parameters:
HOLD_CYC, 2, cycles each array operation is held on the outputs (legal range 1..15)
LEN_W, 6, burst length field width; a write burst is cmd_len+1 beats (max 64)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 MAC, 01 WRITE, 10 CAM, 11 NOP
cmd_addr  input  9  start address: {bank[3:0], row[1:0], col[2:0]}
cmd_bank  input  16  data_bank value for MAC/CAM
cmd_din  input  16  data_in value for MAC/CAM
cmd_len  input  LEN_W  write beats minus one; ignored for non-WRITE
wd_valid  input  1  weight word valid
wd_ready  output  1  sequencer consumes a weight word
wd_data  input  16  weight word, driven onto data_bank during WRITE
op_code  output  2  array op code
addr  output  9  array address
data_bank  output  16  array bank data
data_in  output  16  array input vector
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a rising edge) sets: op_code=2'b11, addr=0, data_bank=0, data_in=0, cmd_ready=0, wd_ready=0, busy=0, done=0, state=IDLE.
- Reset takes priority over all events. A reset mid-burst drops the remaining beats; no done is issued.
- FSM states: IDLE, WAIT_WD, DRIVE, DONE.
- IDLE:
  - cmd_ready=1 and op_code=11.
  - Accept when cmd_valid & cmd_ready.
    - NOP goes to DONE.
    - MAC/CAM: latch addr, data_bank=cmd_bank, data_in=cmd_din, op_code=cmd_op; go to DRIVE.
    - WRITE: latch addr=cmd_addr, beat counter=cmd_len; go to WAIT_WD.
- WAIT_WD:
  - op_code=11, wd_ready=1.
  - On wd_valid: op_code=01, data_bank=wd_data, data_in=0, addr=current address; go to DRIVE.
- DRIVE:
  - Outputs are held for exactly HOLD_CYC cycles, counted by the hold counter.
  - In the final hold cycle of a non-last WRITE beat, wd_ready=1.
    - If wd_valid is also 1, the next beat starts on the next cycle with no gap: addr[8:3] incremented, new data_bank, counter decremented.
    - Otherwise go to WAIT_WD with addr[8:3] incremented.
  - After the final hold cycle of the last beat, or of MAC/CAM, go to DONE.
- Address increment:
  - addr[8:3] increments modulo 64, so 9'b1111_11_xxx wraps to 9'b0000_00_xxx.
  - addr[2:0] is held from cmd_addr.
- DONE:
  - One cycle with done=1, op_code=11, cmd_ready=0; then IDLE.
  - data_bank/data_in/addr keep their last values.
- Timing and throughput:
  - A command accepted at edge N is driven from edge N+1 to edge N+HOLD_CYC.
  - done is high in cycle N+HOLD_CYC+1.
  - Minimum MAC/CAM throughput is one command per HOLD_CYC+2 cycles.
- cmd_ready is 0 outside IDLE; cmd_valid is ignored there.
- wd_ready is 0 except as stated above; wd_valid with wd_ready=0 is ignored.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with cmd_valid=1 -> op_code=11, all data outputs 0, cmd_ready=0, busy=0. First cycle after release: cmd_ready=1.
2. MAC: addr=9'h000, cmd_bank=16'h0010, cmd_din=16'hFFFF, HOLD_CYC=2 -> op_code=00 with those values for exactly 2 cycles; done pulse on the next cycle; op_code=11 after.
3. Gapless write burst: cmd_addr=9'b0000_00_000, cmd_len=3, wd_valid=1 continuously with 16'h0000..0003 -> addr 0x000, 0x008, 0x010, 0x018, each for 2 cycles with op_code=01, data_in=0. 8 consecutive drive cycles, then one done pulse.
4. Stalled write with wrap: cmd_addr=9'b1111_11_000, cmd_len=1, second wd_valid delayed 3 cycles -> beat 1 at 0x1F8; op_code=11 during the stall; beat 2 at 0x000 with data_bank=second word.
5. Mid-burst reset: cmd_len=7, assert rst_n=0 during beat 3 -> all outputs return to reset values at the next edge; no done; a new CAM command (op 10, data_bank=16'h000F) is accepted afterwards and executes normally.
6. NOP and busy: NOP command -> done the cycle after accept with no non-11 op_code. cmd_valid held high during a MAC -> only one command accepted.
